bpi_cmd_seq: RTL

BPI_CMD_SEQ -- requirements
Module: bpi_cmd_seq

---
 rtl/bpi_cmd_seq.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bpi_cmd_seq.sv
// bpi_cmd_seq: sequences the command words of a parallel NOR (BPI) flash for
// READ, PROGRAM, ERASE, UNLOCK, LOCK, READ_STATUS and CLEAR_STATUS requests.
// Each step is one bus cycle (write or read) handed to a lower flash interface.
// PROGRAM and ERASE end with a status poll loop, a bounded timeout, an optional
// status clear and a return to read-array mode.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   CMD_VALID/CODE/ADDR/DATA command request (code 0..7, others rejected)
//   CMD_ACK                  one-cycle accept pulse (combinational, IDLE only)
//   SEQ_BUSY, DONE, ERROR    sequence in progress, completion pulse, result
//   STATUS                   last flash status byte captured
//   RD_DATA, RD_VALID        read result and its pulse (READ / READ_STATUS)
//   ADDR, CMD_DATA_OUT, OP   bus-cycle request (OP 01 write, 10 read, 00 idle)
//   EXECUTE                  one-cycle start strobe for the bus cycle
//   DATA_IN, LOAD_DATA, BUSY read data, its strobe, interface busy
module bpi_cmd_seq #(
    parameter logic [15:0] POLL_LIMIT = 16'd4000,
    parameter int unsigned GUARD      = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    input  logic [3:0]  CMD_CODE,
    input  logic [22:0] CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    output logic        CMD_ACK,
    output logic        SEQ_BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [7:0]  STATUS,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic [22:0] ADDR,
    output logic [15:0] CMD_DATA_OUT,
    output logic [1:0]  OP,
    output logic        EXECUTE,
    input  logic [15:0] DATA_IN,
    input  logic        LOAD_DATA,
    input  logic        BUSY
);

    typedef enum logic [2:0] {
        StIdle, StIssue, StWait, StNext, StPollChk, StFinish
    } state_e;

    localparam logic [3:0] CmdNop     = 4'd0;
    localparam logic [3:0] CmdRead    = 4'd1;
    localparam logic [3:0] CmdProgram = 4'd2;
    localparam logic [3:0] CmdErase   = 4'd3;
    localparam logic [3:0] CmdUnlock  = 4'd4;
    localparam logic [3:0] CmdLock    = 4'd5;
    localparam logic [3:0] CmdRdStat  = 4'd6;
    localparam logic [3:0] CmdClrStat = 4'd7;

    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpRead    = 2'b10;
    // Status bits 5,4,3,1: erase, program, VPP and block-lock errors.
    localparam logic [7:0] ErrMask   = 8'h3A;
    localparam logic [7:0] GuardInit = 8'(GUARD);

    state_e      state_q, state_d;
    logic [3:0]  code_q, code_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  guard_q, guard_d;
    logic [15:0] poll_q, poll_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic [7:0]  status_q, status_d;
    logic        error_q, error_d;

    logic        step_rd;
    logic [15:0] step_wdata;

    // Micro-program: bus cycle for (command, step). PROGRAM/ERASE share steps
    // 2..5: read-status cmd, poll read, clear status (error only), read array.
    always_comb begin
        step_rd    = 1'b0;
        step_wdata = 16'h0000;
        case (code_q)
            CmdRead: begin
                if (step_q == 3'd0) step_wdata = 16'h00FF;
                else                step_rd    = 1'b1;
            end
            CmdProgram, CmdErase: begin
                case (step_q)
                    3'd0:    step_wdata = (code_q == CmdProgram) ? 16'h0040 : 16'h0020;
                    3'd1:    step_wdata = (code_q == CmdProgram) ? wdata_q : 16'h00D0;
                    3'd2:    step_wdata = 16'h0070;
                    3'd3:    step_rd    = 1'b1;
                    3'd4:    step_wdata = 16'h0050;
                    default: step_wdata = 16'h00FF;
                endcase
            end
            CmdUnlock, CmdLock: begin
                if (step_q == 3'd0)          step_wdata = 16'h0060;
                else if (code_q == CmdLock)  step_wdata = 16'h0001;
                else                         step_wdata = 16'h00D0;
            end
            CmdRdStat: begin
                if (step_q == 3'd0) step_wdata = 16'h0070;
                else                step_rd    = 1'b1;
            end
            CmdClrStat: step_wdata = 16'h0050;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        step_d       = step_q;
        guard_d      = guard_q;
        poll_d       = poll_q;
        cap_d        = cap_q;
        rd_data_d    = rd_data_q;
        status_d     = status_q;
        error_d      = error_q;
        CMD_ACK      = 1'b0;
        EXECUTE      = 1'b0;
        DONE         = 1'b0;
        RD_VALID     = 1'b0;
        OP           = 2'b00;
        CMD_DATA_OUT = 16'h0000;

        unique case (state_q)
            StIdle: begin
                if (CMD_VALID && !RST) begin
                    CMD_ACK = 1'b1;
                    code_d  = CMD_CODE;
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_DATA;
                    step_d  = 3'd0;
                    error_d = CMD_CODE[3];
                    state_d = (CMD_CODE == CmdNop || CMD_CODE[3]) ? StFinish : StIssue;
                end
            end
            StIssue: begin
                if (!BUSY) begin
                    EXECUTE      = 1'b1;
                    OP           = step_rd ? OpRead : OpWrite;
                    CMD_DATA_OUT = step_rd ? 16'h0000 : step_wdata;
                    guard_d      = GuardInit;
                    state_d      = StWait;
                end
            end
            StWait: begin
                OP           = step_rd ? OpRead : OpWrite;
                CMD_DATA_OUT = step_rd ? 16'h0000 : step_wdata;
                if (step_rd && LOAD_DATA) cap_d = DATA_IN;
                // BUSY may lag EXECUTE, so it is not trusted during the guard.
                if (guard_q != 8'd0)  guard_d = guard_q - 8'd1;
                else if (!BUSY)       state_d = StNext;
            end
            StNext: begin
                state_d = StIssue;
                step_d  = step_q + 3'd1;
                case (code_q)
                    CmdRead, CmdRdStat: begin
                        if (step_q != 3'd0) begin
                            state_d   = StFinish;
                            rd_data_d = cap_q;
                            if (code_q == CmdRdStat) status_d = cap_q[7:0];
                        end
                    end
                    CmdProgram, CmdErase: begin
                        case (step_q)
                            3'd1: poll_d = 16'd0;
                            3'd3: begin
                                poll_d  = poll_q + 16'd1;
                                step_d  = step_q;
                                state_d = StPollChk;
                            end
                            3'd5: state_d = StFinish;
                            default: ;
                        endcase
                    end
                    CmdUnlock, CmdLock: begin
                        if (step_q != 3'd0) state_d = StFinish;
                    end
                    default: state_d = StFinish;
                endcase
            end
            StPollChk: begin
                state_d = StIssue;
                if (cap_q[7]) begin
                    status_d = cap_q[7:0];
                    if (|(cap_q[7:0] & ErrMask)) begin
                        error_d = 1'b1;
                        step_d  = 3'd4;
                    end else begin
                        step_d  = 3'd5;
                    end
                end else if (poll_q >= POLL_LIMIT) begin
                    status_d = cap_q[7:0];
                    error_d  = 1'b1;
                    step_d   = 3'd4;
                end
            end
            StFinish: begin
                DONE     = 1'b1;
                RD_VALID = (code_q == CmdRead) || (code_q == CmdRdStat);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            code_q    <= 4'd0;
            addr_q    <= 23'd0;
            wdata_q   <= 16'd0;
            step_q    <= 3'd0;
            guard_q   <= 8'd0;
            poll_q    <= 16'd0;
            cap_q     <= 16'd0;
            rd_data_q <= 16'd0;
            status_q  <= 8'd0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            step_q    <= step_d;
            guard_q   <= guard_d;
            poll_q    <= poll_d;
            cap_q     <= cap_d;
            rd_data_q <= rd_data_d;
            status_q  <= status_d;
            error_q   <= error_d;
        end
    end

    assign SEQ_BUSY = (state_q != StIdle);
    assign ERROR    = error_q;
    assign STATUS   = status_q;
    assign RD_DATA  = rd_data_q;
    assign ADDR     = addr_q;

endmodule
